// File: rtl/jpeg_dqt_parser_pkg.sv
// Shared definitions for the JPEG DQT segment parser: FSM states, marker and
// length constants, and the bit positions of the Pq/Tq header fields.
package jpeg_dqt_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PQTQ,
        S_DATA_HI,
        S_DATA_LO
    } dqt_state_t;

    localparam logic [7:0] DQT_MARKER = 8'hDB;
    // Shortest legal segment: 2 length bytes + 1 Pq/Tq byte + 64 8-bit entries.
    localparam int MIN_LEN = 67;

    localparam int PQ_MSB = 7;
    localparam int PQ_LSB = 4;
    localparam int TQ_MSB = 3;
    localparam int TQ_LSB = 0;

endpackage

// File: rtl/jpeg_zigzag_rom.sv
// Combinational zigzag-position -> natural (row-major) index lookup for 8x8 blocks.
// Instantiated by jpeg_dqt_parser only when JPEG_DQT_DEZIGZAG_EN is defined.
module jpeg_zigzag_rom (
    input  logic [5:0] zz_i,
    output logic [5:0] nat_o
);

    localparam logic [5:0] ZZ_TO_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    assign nat_o = ZZ_TO_NAT[zz_i];

endmodule

// File: rtl/jpeg_dqt_parser.sv
// Walks a DQT segment (length, Pq/Tq, coefficients) and drives the quant table write port.
// Define JPEG_DQT_DEZIGZAG_EN to write coefficients in raster order via jpeg_zigzag_rom.
//
// state     | meaning
// S_IDLE    | waiting for seg_start_i, not accepting bytes
// S_LEN_HI  | expecting segment length MSB
// S_LEN_LO  | expecting segment length LSB, length check
// S_PQTQ    | expecting precision / table id byte of the next table
// S_DATA_HI | expecting high byte of a 16-bit coefficient
// S_DATA_LO | expecting an 8-bit coefficient or the low byte of a 16-bit one
module jpeg_dqt_parser
    import jpeg_dqt_parser_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int MAX_TQ = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       seg_start_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       wr_en_o,
    output logic       wr_color_o,
    output logic [5:0] wr_count_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] tables_loaded_o
);

    dqt_state_t       state_q;
    logic [7:0]       len_hi_q;
    logic [LEN_W-1:0] rem_q;
    logic             pq_q;
    logic [3:0]       tq_q;
    logic [5:0]       k_q;
    logic [7:0]       hi_q;
    logic             wr_en_q;
    logic             wr_color_q;
    logic [5:0]       wr_count_q;
    logic [7:0]       wr_data_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       tables_q;

    logic             accept;
    logic [15:0]      len_full;
    logic [LEN_W-1:0] rem_dec;
    logic             rem_zero;
    logic [3:0]       pq_f;
    logic [3:0]       tq_f;
    logic             tq_ok;
    logic [7:0]       coef;
    logic [5:0]       nat_idx;

    assign in_ready_o = (state_q != S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign accept     = in_valid_i & in_ready_o;
    assign len_full   = {len_hi_q, in_data_i};
    assign rem_dec    = rem_q - LEN_W'(1);
    assign rem_zero   = (rem_dec == '0);
    assign pq_f       = in_data_i[PQ_MSB:PQ_LSB];
    assign tq_f       = in_data_i[TQ_MSB:TQ_LSB];
    assign tq_ok      = (tq_q <= 4'(MAX_TQ));
    // 16-bit entries saturate to the 8-bit storage width.
    assign coef       = (pq_q && (hi_q != 8'h00)) ? 8'hFF : in_data_i;

`ifdef JPEG_DQT_DEZIGZAG_EN
    jpeg_zigzag_rom u_zigzag_rom (
        .zz_i  (k_q),
        .nat_o (nat_idx)
    );
`else
    assign nat_idx = k_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            rem_q      <= '0;
            pq_q       <= 1'b0;
            tq_q       <= '0;
            k_q        <= '0;
            hi_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_color_q <= 1'b0;
            wr_count_q <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            tables_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (seg_start_i) begin
                // Restart also aborts a segment in flight; that is not an error.
                state_q  <= S_LEN_HI;
                error_q  <= 1'b0;
                tables_q <= '0;
            end else if (accept) begin
                case (state_q)
                    S_LEN_HI: begin
                        len_hi_q <= in_data_i;
                        state_q  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        rem_q <= LEN_W'(len_full - 16'd2);
                        if (len_full < 16'(MIN_LEN)) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_PQTQ;
                        end
                    end
                    S_PQTQ: begin
                        rem_q <= rem_dec;
                        pq_q  <= pq_f[0];
                        tq_q  <= tq_f;
                        k_q   <= '0;
                        if (pq_f > 4'd1 || rem_zero) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            if (tq_f > 4'(MAX_TQ)) error_q <= 1'b1;
                            state_q <= pq_f[0] ? S_DATA_HI : S_DATA_LO;
                        end
                    end
                    S_DATA_HI: begin
                        rem_q <= rem_dec;
                        hi_q  <= in_data_i;
                        if (rem_zero) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: begin
                        rem_q <= rem_dec;
                        k_q   <= k_q + 6'd1;
                        if (tq_ok) begin
                            wr_en_q    <= 1'b1;
                            wr_color_q <= tq_q[0];
                            wr_count_q <= nat_idx;
                            wr_data_q  <= coef;
                        end
                        if (k_q == 6'd63) begin
                            if (tq_ok) tables_q[tq_q[0]] <= 1'b1;
                            if (rem_zero) begin
                                done_q  <= ~error_q;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_PQTQ;
                            end
                        end else if (rem_zero) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= pq_q ? S_DATA_HI : S_DATA_LO;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wr_en_o         = wr_en_q;
    assign wr_color_o      = wr_color_q;
    assign wr_count_o      = wr_count_q;
    assign wr_data_o       = wr_data_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign tables_loaded_o = tables_q;

endmodule

// File: tb/tb_jpeg_dqt_parser.sv
// Scoreboard bench for jpeg_dqt_parser: stimulus pushes expected table writes,
// a negedge monitor pops and compares every wr_en pulse.
module tb_jpeg_dqt_parser;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       seg_start_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_ready_o;
    logic       wr_en_o;
    logic       wr_color_o;
    logic [5:0] wr_count_o;
    logic [7:0] wr_data_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [1:0] tables_loaded_o;

    jpeg_dqt_parser dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .seg_start_i     (seg_start_i),
        .in_valid_i      (in_valid_i),
        .in_data_i       (in_data_i),
        .in_ready_o      (in_ready_o),
        .wr_en_o         (wr_en_o),
        .wr_color_o      (wr_color_o),
        .wr_count_o      (wr_count_o),
        .wr_data_o       (wr_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .tables_loaded_o (tables_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       color;
        logic [5:0] cnt;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  zz[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent zigzag walk over anti-diagonals of the 8x8 block.
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    function automatic logic [5:0] exp_idx(input int k);
`ifdef JPEG_DQT_DEZIGZAG_EN
        return 6'(zz[k]);
`else
        return 6'(k);
`endif
    endfunction

    task automatic push_wr(input logic color, input int k, input logic [7:0] data);
        wr_t w;
        w.color = color;
        w.cnt   = exp_idx(k);
        w.data  = data;
        exp_q.push_back(w);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            done_cnt++;
            if (!wr_en_o) check("done_with_wr_en", {31'd0, wr_en_o}, 32'd1);
        end
        if (!rst_i && wr_en_o) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_color", {31'd0, wr_color_o}, {31'd0, e.color});
                check("wr_count", {26'd0, wr_count_o}, {26'd0, e.cnt});
                check("wr_data", {24'd0, wr_data_o}, {24'd0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        for (int i = 0; i < gap; i++) begin
            in_valid_i = 1'b0;
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b1;
        in_data_i  = b;
        while (!in_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic start_seg();
        seg_start_i = 1'b1;
        @(posedge clk_i); #1;
        seg_start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 500) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int d0, w0;
        build_zz();
        rst_i = 1'b1; seg_start_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_error", {31'd0, error_o}, 32'd0);
        check("rst_tables", {30'd0, tables_loaded_o}, 32'd0);
        check("rst_wr", {24'd0, wr_en_o, wr_count_o, wr_data_o[0]}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // A: single 8-bit Y table
        d0 = done_cnt;
        start_seg();
        check("A_busy", {31'd0, busy_o}, 32'd1);
        check("A_in_ready", {31'd0, in_ready_o}, 32'd1);
        send_byte(8'h00, 0); send_byte(8'h43, 0); send_byte(8'h00, 0);
        for (int k = 0; k < 64; k++) begin
            push_wr(1'b0, k, 8'(k + 1));
            send_byte(8'(k + 1), 0);
        end
        wait_idle();
        check("A_done", done_cnt - d0, 1);
        check("A_tables", {30'd0, tables_loaded_o}, 32'h1);
        check("A_error", {31'd0, error_o}, 32'd0);
        check("A_drained", exp_q.size(), 0);

        // B: two 8-bit tables, Y then C
        d0 = done_cnt;
        start_seg();
        send_byte(8'h00, 0); send_byte(8'h84, 0); send_byte(8'h00, 0);
        for (int k = 0; k < 64; k++) begin
            push_wr(1'b0, k, 8'(2 * k));
            send_byte(8'(2 * k), 0);
        end
        send_byte(8'h01, 0);
        for (int k = 0; k < 64; k++) begin
            push_wr(1'b1, k, 8'(255 - k));
            send_byte(8'(255 - k), 0);
        end
        wait_idle();
        check("B_done", done_cnt - d0, 1);
        check("B_tables", {30'd0, tables_loaded_o}, 32'h3);
        check("B_drained", exp_q.size(), 0);

        // C: 16-bit table, saturation on every odd entry
        d0 = done_cnt;
        start_seg();
        send_byte(8'h00, 0); send_byte(8'h83, 0); send_byte(8'h10, 0);
        for (int k = 0; k < 64; k++) begin
            if (k % 2 == 0) begin
                push_wr(1'b0, k, 8'h10);
                send_byte(8'h00, 0); send_byte(8'h10, 0);
            end else begin
                push_wr(1'b0, k, 8'hFF);
                send_byte(8'h01, 0); send_byte(8'h00, 0);
            end
        end
        wait_idle();
        check("C_done", done_cnt - d0, 1);
        check("C_tables", {30'd0, tables_loaded_o}, 32'h1);
        check("C_drained", exp_q.size(), 0);

        // D: length too short
        d0 = done_cnt; w0 = wr_cnt;
        start_seg();
        send_byte(8'h00, 0); send_byte(8'h30, 0);
        wait_idle();
        check("D_error", {31'd0, error_o}, 32'd1);
        check("D_busy", {31'd0, busy_o}, 32'd0);
        check("D_writes", wr_cnt - w0, 0);
        check("D_done", done_cnt - d0, 0);

        // E: Pq = 2 rejected
        d0 = done_cnt; w0 = wr_cnt;
        start_seg();
        check("E_error_cleared", {31'd0, error_o}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h43, 0); send_byte(8'h20, 0);
        wait_idle();
        check("E_error", {31'd0, error_o}, 32'd1);
        check("E_writes", wr_cnt - w0, 0);
        check("E_done", done_cnt - d0, 0);

        // F: abort at byte 20 of a C table, then a full Y segment with gaps
        d0 = done_cnt;
        start_seg();
        send_byte(8'h00, 1); send_byte(8'h43, 2); send_byte(8'h01, 0);
        for (int k = 0; k < 20; k++) begin
            push_wr(1'b1, k, 8'(8'h80 + k));
            send_byte(8'(8'h80 + k), $urandom_range(0, 3));
        end
        start_seg();
        check("F_restart_busy", {31'd0, busy_o}, 32'd1);
        check("F_restart_tables", {30'd0, tables_loaded_o}, 32'h0);
        send_byte(8'h00, 2); send_byte(8'h43, 0); send_byte(8'h00, 3);
        for (int k = 0; k < 64; k++) begin
            push_wr(1'b0, k, 8'(8'h40 ^ k));
            send_byte(8'(8'h40 ^ k), $urandom_range(0, 3));
        end
        wait_idle();
        check("F_error", {31'd0, error_o}, 32'd0);
        check("F_done", done_cnt - d0, 1);
        check("F_tables", {30'd0, tables_loaded_o}, 32'h1);
        check("F_drained", exp_q.size(), 0);

        // Reset mid-segment returns to idle
        start_seg();
        send_byte(8'h00, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("R_busy", {31'd0, busy_o}, 32'd0);
        check("R_in_ready", {31'd0, in_ready_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
